// File: rtl/endproperty_unit.sv
// Floating-point adder or multiplier on {sign, exponent, mantissa} operands.
// Round to nearest-even, saturate on overflow, flush denormals/underflow to zero.
module endproperty_unit #(
  parameter string OP     = "ADD",
  parameter int    EXP_W  = 8,
  parameter int    MANT_W = 23,
  parameter bit    PIPE   = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [EXP_W+MANT_W:0]   a_i,
  input  logic [EXP_W+MANT_W:0]   b_i,
  output logic [EXP_W+MANT_W:0]   result_o
);

  localparam int M    = MANT_W + 1;      // mantissa incl. hidden bit
  localparam int IE   = EXP_W + 3;       // signed working exponent width
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;

  localparam logic [EXP_W-1:0]        EMAX   = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic signed [IE-1:0]    EMAX_S = $signed({3'b000, EMAX});
  localparam logic signed [IE-1:0]    BIAS_S = IE'(BIAS);
  localparam logic signed [IE-1:0]    ONE_S  = IE'(1);

  typedef struct packed {
    logic              s;
    logic [EXP_W-1:0]  e;
    logic [MANT_W-1:0] m;
  } flt_t;

  logic [EXP_W+MANT_W:0] result_d, result_q;

  // Denormals become signed zero; the all-ones exponent is read as max finite.
  function automatic flt_t sanitize(input flt_t x);
    flt_t y;
    y = x;
    if (x.e == '0) y.m = '0;
    else if (&x.e) begin
      y.e = EMAX;
      y.m = '1;
    end
    return y;
  endfunction

  function automatic flt_t round_pack(input logic s, input logic signed [IE-1:0] e,
                                      input logic [M-1:0] man, input logic g,
                                      input logic st);
    logic [M:0]               mr;
    logic signed [IE-1:0]     en;
    flt_t                     r;
    mr  = {1'b0, man} + {{M{1'b0}}, g & (st | man[0])};
    en  = e + {{(IE-1){1'b0}}, mr[M]};
    r.s = s;
    if (en > EMAX_S) begin
      r.e = EMAX;
      r.m = '1;
    end else if (en < ONE_S) begin
      r.e = '0;
      r.m = '0;
    end else begin
      r.e = en[EXP_W-1:0];
      r.m = mr[M] ? mr[M-1:1] : mr[M-2:0];
    end
    return r;
  endfunction

  function automatic int lzc(input logic [M+2:0] v);
    int n;
    n = M + 3;
    for (int i = 0; i <= M + 2; i++)
      if (v[i]) n = M + 2 - i;
    return n;
  endfunction

  function automatic flt_t fp_add(input flt_t a, input flt_t b);
    flt_t                    x, y, r;
    logic [EXP_W-1:0]        d;
    int                      dsh, lz;
    logic [2*(M+3)-1:0]      ext;
    logic [M+2:0]            xm, yal, norm;
    logic [M+3:0]            sum;
    logic signed [IE-1:0]    e;
    logic                    a_z, b_z;
    a_z = (a.e == '0);
    b_z = (b.e == '0);
    r   = '0;
    if (a_z && b_z) r.s = a.s & b.s;
    else if (a_z)   r = b;
    else if (b_z)   r = a;
    else begin
      if ({a.e, a.m} >= {b.e, b.m}) begin
        x = a; y = b;
      end else begin
        x = b; y = a;
      end
      d   = x.e - y.e;
      dsh = (int'(d) > M + 3) ? M + 3 : int'(d);
      // Upper half is the aligned operand; anything shifted below it is sticky.
      ext = {1'b1, y.m, 3'b000, {(M+3){1'b0}}} >> dsh;
      yal = {ext[2*M+5:M+4], ext[M+3] | (|ext[M+2:0])};
      xm  = {1'b1, x.m, 3'b000};
      sum = (x.s ^ y.s) ? ({1'b0, xm} - {1'b0, yal}) : ({1'b0, xm} + {1'b0, yal});
      if (sum == '0) r = '0;
      else begin
        if (sum[M+3]) begin
          norm = {sum[M+3:2], sum[1] | sum[0]};
          e    = $signed({3'b000, x.e}) + ONE_S;
        end else begin
          lz   = lzc(sum[M+2:0]);
          norm = sum[M+2:0] << lz;
          e    = $signed({3'b000, x.e}) - IE'(lz);
        end
        r = round_pack(x.s, e, norm[M+2:3], norm[2], norm[1] | norm[0]);
      end
    end
    return r;
  endfunction

  function automatic flt_t fp_mul(input flt_t a, input flt_t b);
    flt_t                    r;
    logic [2*M-1:0]          prod;
    logic signed [IE-1:0]    e;
    logic                    s;
    s = a.s ^ b.s;
    r = '0;
    if (a.e == '0 || b.e == '0) r.s = s;
    else begin
      prod = {{M{1'b0}}, 1'b1, a.m} * {{M{1'b0}}, 1'b1, b.m};
      e    = $signed({3'b000, a.e}) + $signed({3'b000, b.e}) - BIAS_S;
      if (prod[2*M-1])
        r = round_pack(s, e + ONE_S, prod[2*M-1:M], prod[M-1], |prod[M-2:0]);
      else
        r = round_pack(s, e, prod[2*M-2:M-1], prod[M-2], |prod[M-3:0]);
    end
    return r;
  endfunction

  generate
    if (OP == "MULT") begin : g_mul
      assign result_d = fp_mul(sanitize(flt_t'(a_i)), sanitize(flt_t'(b_i)));
    end else begin : g_add
      assign result_d = fp_add(sanitize(flt_t'(a_i)), sanitize(flt_t'(b_i)));
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) result_q <= '0;
    else       result_q <= result_d;
  end

  assign result_o = PIPE ? result_q : result_d;

endmodule

// File: tb/tb_endproperty_unit.sv
// Directed checks of the FP adder/multiplier, plus reset and latency of the registered variant.
module tb_endproperty_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] add_a = '0, add_b = '0, add_r;
  logic [31:0] mul_a = '0, mul_b = '0, mul_r;
  logic [31:0] p_a = '0, p_b = '0, p_r;
  int          n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  endproperty_unit #(.OP("ADD"), .EXP_W(8), .MANT_W(23), .PIPE(1'b0)) u_add (
    .clk_i(clk), .rst_i(rst), .a_i(add_a), .b_i(add_b), .result_o(add_r));
  endproperty_unit #(.OP("MULT"), .EXP_W(8), .MANT_W(23), .PIPE(1'b0)) u_mul (
    .clk_i(clk), .rst_i(rst), .a_i(mul_a), .b_i(mul_b), .result_o(mul_r));
  endproperty_unit #(.OP("ADD"), .EXP_W(8), .MANT_W(23), .PIPE(1'b1)) u_pip (
    .clk_i(clk), .rst_i(rst), .a_i(p_a), .b_i(p_b), .result_o(p_r));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_chk++;
    if (got === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp_v);
  endtask

  task automatic t_add(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e);
    @(negedge clk); add_a = a; add_b = b;
    @(posedge clk); #1; chk(tag, add_r, e);
  endtask

  task automatic t_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e);
    @(negedge clk); mul_a = a; mul_b = b;
    @(posedge clk); #1; chk(tag, mul_r, e);
  endtask

  // Exact single-precision encoding of a small integer.
  function automatic logic [31:0] int2f(input int v);
    logic [31:0] mag;
    int          msb;
    if (v == 0) return 32'h0;
    mag = (v < 0) ? 32'(-v) : 32'(v);
    msb = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) msb = i;
    return {v < 0, 8'(127 + msb), 23'(mag << (23 - msb))};
  endfunction

  int          ra, rb;
  logic [31:0] expv;

  initial begin
    p_a = 32'h3F800000; p_b = 32'h3F800000;
    #2 rst = 1'b1;
    #1 chk("pip_rst", p_r, 32'h0);
    @(posedge clk); #1; chk("pip_rst_hold", p_r, 32'h0);

    // 1.5 + 2.25 held across several clock edges
    @(negedge clk); add_a = 32'h3FC00000; add_b = 32'h40100000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1; chk("add_basic", add_r, 32'h40700000);
    end
    t_add("add_comm",     32'h40100000, 32'h3FC00000, 32'h40700000);
    t_add("add_cancel",   32'h3F800000, 32'hBF800000, 32'h00000000);
    t_add("add_zero",     32'h3F000000, 32'h00000000, 32'h3F000000);
    t_add("add_zero_l",   32'h00000000, 32'h3F000000, 32'h3F000000);
    t_add("add_far",      32'h49800000, 32'h3A800000, 32'h49800000);
    t_add("add_tie_even", 32'h3F800000, 32'h33800000, 32'h3F800000);
    t_add("add_tie_up",   32'h3F800001, 32'h33800000, 32'h3F800002);
    t_add("add_ulp",      32'h3F800000, 32'h34000000, 32'h3F800001);
    t_add("add_sub_norm", 32'h3F800000, 32'hBF400000, 32'h3E800000);
    t_add("add_sub",      32'h40400000, 32'hBF800000, 32'h40000000);
    t_add("add_sat",      32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF);
    t_add("add_denorm",   32'h00000001, 32'h3F800000, 32'h3F800000);
    t_add("add_negneg",   32'hBFC00000, 32'hC0100000, 32'hC0700000);

    t_mul("mul_basic",   32'h3FC00000, 32'hC0000000, 32'hC0400000);
    t_mul("mul_zero",    32'h00000000, 32'hC0E00000, 32'h80000000);
    t_mul("mul_ovf",     32'h71800000, 32'h71800000, 32'h7F7FFFFF);
    t_mul("mul_neg_ovf", 32'hF1800000, 32'h71800000, 32'hFF7FFFFF);
    t_mul("mul_unf",     32'h0D800000, 32'h0D800000, 32'h00000000);
    t_mul("mul_norm",    32'h40400000, 32'h40400000, 32'h41100000);
    t_mul("mul_rnd",     32'h3F800001, 32'h3F800001, 32'h3F800002);
    t_mul("mul_negneg",  32'hC0000000, 32'hC0000000, 32'h40800000);

    // Registered variant: one-cycle latency, register must hold between edges
    @(negedge clk);
    rst = 1'b0;
    add_a = 32'h3FC00000; add_b = 32'h40100000;
    ra = int'($urandom_range(2000)) - 1000;
    rb = int'($urandom_range(2000)) - 1000;
    p_a = int2f(ra); p_b = int2f(rb); expv = int2f(ra + rb);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1; chk("pip_data", p_r, expv);
      ra = int'($urandom_range(2000)) - 1000;
      rb = int'($urandom_range(2000)) - 1000;
      p_a = int2f(ra); p_b = int2f(rb);
      #1 chk("pip_hold", p_r, expv);
      expv = int2f(ra + rb);
    end
    @(posedge clk); #1; chk("pip_data", p_r, expv);
    p_a = 32'h40400000; p_b = 32'h40800000;
    @(posedge clk); #1; chk("pip_last", p_r, 32'h40E00000);

    #2 rst = 1'b1;
    #1 chk("pip_async_rst", p_r, 32'h0);
    chk("add_rst_indep", add_r, 32'h40700000);
    @(posedge clk); #1; chk("pip_rst_hold2", p_r, 32'h0);
    @(negedge clk); rst = 1'b0; p_a = 32'h3FC00000; p_b = 32'h40100000;
    #1 chk("pip_pre_edge", p_r, 32'h0);
    @(posedge clk); #1; chk("pip_first", p_r, 32'h40700000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
